fpga_clkratio_seq: RTL and testbench
====================================

// Module: fpga_clkratio_seq
// PURPOSE
//  APB-programmable sequencer for the CPU:BIU clock ratio and clock enable.
//  - Replaces the immediate ratio write with a safe handshake: quiesce the BIU, gate clk_en, apply the ratio, settle, release.
//  - Sits beside the FPGA clock generator on the peripheral APB; drives pad_biu_clkratio and clk_en to the core wrapper.
// PARAMETERS
//  GATE_CYC     4    per_clk cycles clk_en held low before the ratio changes (>=1)
//  SETTLE_CYC   8    per_clk cycles clk_en held low after the ratio changes (>=1)
//  TIMEOUT_CYC  256  max cycles waiting for quiesce_ack (only with CLKRATIO_SEQ_TIMEOUT_EN)
//  CNT_W        9    counter width; must hold max(GATE_CYC,SETTLE_CYC,TIMEOUT_CYC)
// PORTS
//  per_clk           in   1   peripheral/system clock
//  clkrst_b          in   1   asynchronous active-low reset
//  psel              in   1   APB select
//  penable           in   1   APB enable
//  pwrite            in   1   APB write
//  paddr             in   4   APB byte address [3:0]
//  pwdata            in   32  APB write data
//  prdata            out  32  APB read data, registered
//  pready            out  1   tied 1 (zero wait state)
//  quiesce_req       out  1   request to the BIU to drain and hold traffic
//  quiesce_ack       in   1   BIU idle; synchronous to per_clk
//  clk_en            out  1   core clock enable
//  pad_biu_clkratio  out  3   active clock ratio
//  seq_done_irq      out  1   one-cycle pulse when a sequence ends (success or abort)
// BEHAVIOUR
//  Reset values: clk_en=1, pad_biu_clkratio=0, quiesce_req=0, prdata=0, seq_done_irq=0, FSM=IDLE, STATUS=0.
//  Registers: write = psel&pwrite&penable; read = psel&!pwrite&penable loads prdata at the same edge.
//   0x0 RATIO   RW  [2:0] target ratio; reads return the target.
//   0x4 STATUS  RO/W1C  [0] busy(RO), [6:4] pad_biu_clkratio(RO), [8] werr(W1C), [9] tmo(W1C).
//   Other offsets: reads return 0, writes are ignored.
//  A RATIO write in IDLE with a value != pad_biu_clkratio stores the target and moves to REQ on the next edge.
//  A RATIO write in IDLE with a value equal to pad_biu_clkratio stores the target only; no sequence, no irq.
//  A RATIO write while busy (FSM != IDLE) is dropped and sets werr; the target is unchanged.
//  FSM (one transition per per_clk edge):
//   IDLE    -> REQ on an accepted write.
//   REQ     quiesce_req=1; -> GATE on the first cycle quiesce_ack=1. Ack already high on entry: one cycle in REQ.
//   GATE    clk_en=0 for exactly GATE_CYC cycles -> APPLY.
//   APPLY   single cycle; pad_biu_clkratio <= target -> SETTLE.
//   SETTLE  clk_en=0 for exactly SETTLE_CYC cycles -> RELEASE.
//   RELEASE clk_en=1, quiesce_req=0; -> IDLE when quiesce_ack=0; pulse seq_done_irq on that edge.
//  clk_en is registered: it falls on the edge entering GATE and rises on the edge entering RELEASE.
//  Total clk_en low time = GATE_CYC+1+SETTLE_CYC cycles.
//  busy = (FSM != IDLE).
//  Counter: loads 0 on state entry and compares at N-1; no wrap is possible.
//  A W1C write and a same-cycle set of the same bit: the set wins.
//  Reset mid-sequence: everything returns to reset values immediately, including clk_en=1 and ratio=0.
// CONFIGURATION
//  CLKRATIO_SEQ_TIMEOUT_EN defined:
//   - REQ counts cycles; ack missing for TIMEOUT_CYC cycles -> IDLE.
//   - That exit drops quiesce_req, leaves the ratio unchanged, sets tmo and pulses seq_done_irq.
//  CLKRATIO_SEQ_TIMEOUT_EN undefined:
//   - REQ waits for ack indefinitely.
//   - tmo reads 0 and the TIMEOUT_CYC logic is absent.
// STRUCTURE
//  Package fpga_clk_pkg: state enum (IDLE,REQ,GATE,APPLY,SETTLE,RELEASE), register offsets, STATUS bit positions.
//  Sub-module fpga_clkratio_regs: APB decode, RATIO/STATUS storage, W1C logic, prdata mux.
//  Top level: FSM, counter, output registers.
// TESTING
//  1. Reset, read STATUS -> 0x0; clk_en=1; ratio=0.
//  2. Write RATIO=3, ack returned 2 cycles after req, GATE=4, SETTLE=8:
//     -> clk_en low exactly 13 cycles; ratio becomes 3 in APPLY; irq pulses once after ack drops; STATUS=0x030.
//  3. Write RATIO=3 when ratio is already 3 -> no quiesce_req, no irq, busy stays 0.
//  4. Write RATIO=5 during SETTLE -> werr=1, sequence completes with the old target.
//     Then write 0x100 to STATUS -> werr=0.
//  5. TIMEOUT_EN, ack never asserted -> after 256 cycles req=0, tmo=1, irq pulse, ratio unchanged.
//     Without the macro: still in REQ at cycle 1000.
//  6. Assert clkrst_b low during GATE -> clk_en=1, ratio=0, req=0 within the same cycle; FSM=IDLE after release.

Source files
------------

// File: rtl/fpga_clkratio_seq_pkg.sv
// Shared encodings for the clock-ratio sequencer: FSM states, register map, STATUS layout.
package fpga_clk_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_GATE    = 3'd2;
  localparam logic [2:0] ST_APPLY   = 3'd3;
  localparam logic [2:0] ST_SETTLE  = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  localparam logic [3:0] OFF_RATIO  = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;

  localparam int STS_BUSY      = 0;
  localparam int STS_RATIO_LSB = 4;
  localparam int STS_WERR      = 8;
  localparam int STS_TMO       = 9;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } apb_req_t;

  function automatic logic [31:0] status_word(input logic busy, input logic [2:0] ratio,
                                              input logic werr, input logic tmo);
    logic [31:0] w;
    w                               = '0;
    w[STS_BUSY]                     = busy;
    w[STS_RATIO_LSB+2:STS_RATIO_LSB] = ratio;
    w[STS_WERR]                     = werr;
    w[STS_TMO]                      = tmo;
    return w;
  endfunction

endpackage

// File: rtl/fpga_clkratio_seq_if.sv
// Peripheral APB slave port of the clock-ratio sequencer.
interface fpga_clkratio_seq_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready);
endinterface

// File: rtl/fpga_clkratio_seq_regs.sv
// APB decode and RATIO/STATUS storage for the clock-ratio sequencer.
// tmo exists only when CLKRATIO_SEQ_TIMEOUT_EN is defined.
module fpga_clkratio_regs
  import fpga_clk_pkg::*;
(
  input  logic              per_clk,
  input  logic              clkrst_b,
  fpga_clkratio_seq_if.slave apb,
  input  logic              busy,
  input  logic [2:0]        cur_ratio,
  input  logic              tmo_set,
  output logic [2:0]        target,
  output logic              seq_start
);

  apb_req_t req;
  logic     ratio_wr, sts_wr, werr_set;
  logic     werr, tmo;

  always_comb begin
    req.wr    = apb.psel & apb.pwrite & apb.penable;
    req.rd    = apb.psel & ~apb.pwrite & apb.penable;
    req.addr  = apb.paddr;
    req.wdata = apb.pwdata;
  end

  assign ratio_wr  = req.wr && (req.addr == OFF_RATIO);
  assign sts_wr    = req.wr && (req.addr == OFF_STATUS);
  assign werr_set  = ratio_wr && busy;
  // Only a real change of ratio launches the handshake.
  assign seq_start = ratio_wr && !busy && (req.wdata[2:0] != cur_ratio);
  assign apb.pready = 1'b1;

  always_ff @(posedge per_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      target <= '0;
      werr   <= 1'b0;
    end else begin
      if (ratio_wr && !busy) target <= req.wdata[2:0];
      // A same-cycle set beats the W1C clear.
      werr <= werr_set | (werr & ~(sts_wr & req.wdata[STS_WERR]));
    end
  end

`ifdef CLKRATIO_SEQ_TIMEOUT_EN
  always_ff @(posedge per_clk or negedge clkrst_b) begin
    if (!clkrst_b) tmo <= 1'b0;
    else           tmo <= tmo_set | (tmo & ~(sts_wr & req.wdata[STS_TMO]));
  end
  wire unused_wdata = ^{req.wdata[31:10], req.wdata[7:3]};
`else
  assign tmo = 1'b0;
  wire unused_wdata = ^{req.wdata[31:10], req.wdata[9], req.wdata[7:3], tmo_set};
`endif

  always_ff @(posedge per_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      apb.prdata <= '0;
    end else if (req.rd) begin
      case (req.addr)
        OFF_RATIO:  apb.prdata <= {29'd0, target};
        OFF_STATUS: apb.prdata <= status_word(busy, cur_ratio, werr, tmo);
        default:    apb.prdata <= '0;
      endcase
    end
  end

endmodule

// File: rtl/fpga_clkratio_seq.sv
// CPU:BIU clock-ratio sequencer: quiesce BIU, gate clk_en, apply ratio, settle, release.
// Optional REQ timeout enabled by defining CLKRATIO_SEQ_TIMEOUT_EN.
module fpga_clkratio_seq
  import fpga_clk_pkg::*;
#(
  parameter int GATE_CYC    = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic              per_clk,
  input  logic              clkrst_b,
  fpga_clkratio_seq_if.slave apb,
  output logic              quiesce_req,
  input  logic              quiesce_ack,
  output logic              clk_en,
  output logic [2:0]        pad_biu_clkratio,
  output logic              seq_done_irq
);

  logic [2:0]       state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       target;
  logic             seq_start, busy, tmo_set, done, counting;

  assign busy = (state != ST_IDLE);

  fpga_clkratio_regs u_regs (
    .per_clk   (per_clk),
    .clkrst_b  (clkrst_b),
    .apb       (apb),
    .busy      (busy),
    .cur_ratio (pad_biu_clkratio),
    .tmo_set   (tmo_set),
    .target    (target),
    .seq_start (seq_start)
  );

  always_comb begin
    nxt      = state;
    tmo_set  = 1'b0;
    done     = 1'b0;
    counting = 1'b0;
    case (state)
      ST_IDLE: if (seq_start) nxt = ST_REQ;
      ST_REQ: begin
`ifdef CLKRATIO_SEQ_TIMEOUT_EN
        counting = 1'b1;
        if (quiesce_ack) nxt = ST_GATE;
        else if (cnt == CNT_W'(TIMEOUT_CYC-1)) begin
          nxt     = ST_IDLE;
          tmo_set = 1'b1;
          done    = 1'b1;
        end
`else
        if (quiesce_ack) nxt = ST_GATE;
`endif
      end
      ST_GATE: begin
        counting = 1'b1;
        if (cnt == CNT_W'(GATE_CYC-1)) nxt = ST_APPLY;
      end
      ST_APPLY: nxt = ST_SETTLE;
      ST_SETTLE: begin
        counting = 1'b1;
        if (cnt == CNT_W'(SETTLE_CYC-1)) nxt = ST_RELEASE;
      end
      ST_RELEASE: if (!quiesce_ack) begin
        nxt  = ST_IDLE;
        done = 1'b1;
      end
      default: nxt = ST_IDLE;
    endcase
  end

`ifndef CLKRATIO_SEQ_TIMEOUT_EN
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  // Counter restarts on every state change, so each timed state sees 0..N-1.
  always_ff @(posedge per_clk or negedge clkrst_b) begin
    if (!clkrst_b)         cnt <= '0;
    else if (nxt != state) cnt <= '0;
    else if (counting)     cnt <= cnt + 1'b1;
  end

  // Outputs are registered from the next state so they switch on the entry edge.
  always_ff @(posedge per_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      state            <= ST_IDLE;
      clk_en           <= 1'b1;
      quiesce_req      <= 1'b0;
      pad_biu_clkratio <= '0;
      seq_done_irq     <= 1'b0;
    end else begin
      state        <= nxt;
      clk_en       <= !(nxt == ST_GATE || nxt == ST_APPLY || nxt == ST_SETTLE);
      quiesce_req  <= (nxt == ST_REQ || nxt == ST_GATE || nxt == ST_APPLY || nxt == ST_SETTLE);
      seq_done_irq <= done;
      if (nxt == ST_APPLY && state == ST_GATE) pad_biu_clkratio <= target;
    end
  end

endmodule

// File: tb/tb_fpga_clkratio_seq.sv
// Randomized bench for fpga_clkratio_seq against a transaction-level model of ratio/target/werr.
module tb_fpga_clkratio_seq;

  localparam int GATE = 4, SETTLE = 8, TMO = 256;
  localparam int LOWLEN = GATE + 1 + SETTLE;

  logic       per_clk = 1'b0, clkrst_b = 1'b0, quiesce_ack = 1'b0;
  logic       quiesce_req, clk_en, seq_done_irq;
  logic [2:0] pad_biu_clkratio;

  fpga_clkratio_seq_if apb ();

  fpga_clkratio_seq dut (
    .per_clk          (per_clk),
    .clkrst_b         (clkrst_b),
    .apb              (apb),
    .quiesce_req      (quiesce_req),
    .quiesce_ack      (quiesce_ack),
    .clk_en           (clk_en),
    .pad_biu_clkratio (pad_biu_clkratio),
    .seq_done_irq     (seq_done_irq)
  );

  always #5 per_clk = ~per_clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // Observers: clk_en low-run length, irq pulses, req cycles, ratio changes outside the gated window.
  int   low_run = 0, last_low = 0, irq_cnt = 0, req_cycles = 0, ratio_bad = 0;
  bit   mon_en = 1'b1;
  logic [2:0] prev_ratio = '0;

  always @(negedge per_clk) begin
    if (!clk_en) low_run++;
    else begin
      if (low_run != 0) last_low = low_run;
      low_run = 0;
    end
    if (seq_done_irq) irq_cnt++;
    if (quiesce_req) req_cycles++;
    if (mon_en && pad_biu_clkratio !== prev_ratio && (clk_en || !quiesce_req)) ratio_bad++;
    prev_ratio = pad_biu_clkratio;
  end

  // Reference state
  logic [2:0] m_ratio = '0, m_target = '0;
  logic       m_werr = 1'b0;

  function automatic logic [31:0] sts(input logic busy, input logic [2:0] r,
                                      input logic werr, input logic tmo);
    return {22'd0, tmo, werr, 1'b0, r, 3'd0, busy};
  endfunction

  task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge per_clk);
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.paddr = a; apb.pwdata = d; apb.penable = 1'b0;
    @(negedge per_clk);
    apb.penable = 1'b1;
    @(negedge per_clk);
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge per_clk);
    apb.psel = 1'b1; apb.pwrite = 1'b0; apb.paddr = a; apb.penable = 1'b0;
    @(negedge per_clk);
    apb.penable = 1'b1;
    @(negedge per_clk);
    d = apb.prdata;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  task automatic wait_req(input logic val, input string tag);
    int n = 0;
    while (quiesce_req !== val && n < 2000) begin @(negedge per_clk); n++; end
    chk(tag, quiesce_req, val);
  endtask

  task automatic wait_clk_en(input logic val, input string tag);
    int n = 0;
    while (clk_en !== val && n < 2000) begin @(negedge per_clk); n++; end
    chk(tag, clk_en, val);
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (seq_done_irq !== 1'b1 && n < 2000) begin @(negedge per_clk); n++; end
    chk(tag, seq_done_irq, 1'b1);
  endtask

  task automatic do_ratio(input logic [2:0] v, input int d, input int r, input bit bwr);
    int irq0, req0;
    logic [31:0] s;
    logic [2:0]  w;
    irq0 = irq_cnt; req0 = req_cycles;
    apb_wr(4'h0, {29'd0, v});
    m_target = v;
    if (v == m_ratio) begin
      repeat (10) @(negedge per_clk);
      chk("noop_req", req_cycles - req0, 0);
      chk("noop_irq", irq_cnt - irq0, 0);
      apb_rd(4'h4, s); chk("noop_sts", s, sts(1'b0, m_ratio, m_werr, 1'b0));
      apb_rd(4'h0, s); chk("noop_tgt", s, {29'd0, v});
      return;
    end
    wait_req(1'b1, "req_rise");
    repeat (d) @(negedge per_clk);
    quiesce_ack = 1'b1;
    wait_clk_en(1'b0, "gate_fall");
    if (bwr) begin
      w = v + 3'd1 + 3'($urandom_range(0, 5));
      apb_wr(4'h0, {29'd0, w});
      m_werr = 1'b1;
    end
    wait_clk_en(1'b1, "gate_rise");
    chk("ratio_applied", pad_biu_clkratio, v);
    m_ratio = v;
    @(negedge per_clk);
    chk("low_len", last_low, LOWLEN);
    chk("req_drop", quiesce_req, 1'b0);
    repeat (r) @(negedge per_clk);
    chk("no_irq_before_ack_drop", irq_cnt - irq0, 0);
    quiesce_ack = 1'b0;
    wait_irq("irq_seen");
    repeat (2) @(negedge per_clk);
    chk("irq_once", irq_cnt - irq0, 1);
    apb_rd(4'h4, s); chk("sts_after", s, sts(1'b0, m_ratio, m_werr, 1'b0));
    apb_rd(4'h0, s); chk("tgt_after", s, {29'd0, m_target});
    if (m_werr) begin
      apb_wr(4'h4, 32'h100);
      m_werr = 1'b0;
      apb_rd(4'h4, s); chk("werr_clr", s, sts(1'b0, m_ratio, 1'b0, 1'b0));
    end
  endtask

  initial begin
    logic [31:0] s;
    logic [2:0]  v;
    int          irq0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
    repeat (3) @(negedge per_clk);
    chk("rst_clk_en", clk_en, 1'b1);
    chk("rst_ratio", pad_biu_clkratio, 3'd0);
    chk("rst_req", quiesce_req, 1'b0);
    chk("rst_irq", seq_done_irq, 1'b0);
    chk("rst_prdata", apb.prdata, 32'd0);
    clkrst_b = 1'b1;
    apb_rd(4'h4, s); chk("rst_sts", s, 32'd0);

    do_ratio(3'd3, 2, 1, 1'b0);
    chk("sts_0x030", sts(1'b0, m_ratio, m_werr, 1'b0), 32'h30);
    do_ratio(3'd3, 0, 0, 1'b0);
    do_ratio(3'd5, 1, 2, 1'b1);

    for (int i = 0; i < 8; i++)
      do_ratio(3'($urandom_range(0, 7)), $urandom_range(0, 4), $urandom_range(0, 3),
               1'($urandom_range(0, 1)));

    apb_rd(4'h8, s); chk("unmapped_rd", s, 32'd0);
    apb_wr(4'hC, 32'hFFFF_FFFF);
    apb_rd(4'h4, s); chk("unmapped_wr", s, sts(1'b0, m_ratio, m_werr, 1'b0));

    // Quiesce ack never arrives.
    v = m_ratio ^ 3'd1;
    irq0 = irq_cnt;
    apb_wr(4'h0, {29'd0, v});
    m_target = v;
    wait_req(1'b1, "tmo_req_rise");
`ifdef CLKRATIO_SEQ_TIMEOUT_EN
    repeat (TMO + 20) @(negedge per_clk);
    chk("tmo_req_drop", quiesce_req, 1'b0);
    chk("tmo_irq", irq_cnt - irq0, 1);
    chk("tmo_ratio", pad_biu_clkratio, m_ratio);
    apb_rd(4'h4, s); chk("tmo_sts", s, sts(1'b0, m_ratio, m_werr, 1'b1));
    apb_wr(4'h4, 32'h200);
    apb_rd(4'h4, s); chk("tmo_clr", s, sts(1'b0, m_ratio, m_werr, 1'b0));
`else
    repeat (1000) @(negedge per_clk);
    chk("hold_req", quiesce_req, 1'b1);
    chk("hold_irq", irq_cnt - irq0, 0);
    apb_rd(4'h4, s); chk("hold_sts", s, sts(1'b1, m_ratio, m_werr, 1'b0));
    quiesce_ack = 1'b1;
    wait_clk_en(1'b0, "hold_gate_fall");
    wait_clk_en(1'b1, "hold_gate_rise");
    m_ratio = v;
    chk("hold_ratio", pad_biu_clkratio, m_ratio);
    quiesce_ack = 1'b0;
    wait_irq("hold_irq_seen");
    repeat (2) @(negedge per_clk);
`endif

    // Reset in the middle of GATE.
    v = m_ratio ^ 3'd2;
    apb_wr(4'h0, {29'd0, v});
    wait_req(1'b1, "mid_req_rise");
    quiesce_ack = 1'b1;
    wait_clk_en(1'b0, "mid_gate_fall");
    mon_en = 1'b0;
    #2 clkrst_b = 1'b0;
    #1;
    chk("mid_clk_en", clk_en, 1'b1);
    chk("mid_ratio", pad_biu_clkratio, 3'd0);
    chk("mid_req", quiesce_req, 1'b0);
    @(negedge per_clk);
    clkrst_b = 1'b1; quiesce_ack = 1'b0;
    m_ratio = '0; m_target = '0; m_werr = 1'b0;
    @(negedge per_clk);
    mon_en = 1'b1;
    apb_rd(4'h4, s); chk("mid_sts", s, 32'd0);
    apb_rd(4'h0, s); chk("mid_tgt", s, 32'd0);
    do_ratio(3'd6, 3, 1, 1'b0);

    chk("ratio_only_when_gated", ratio_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
